piece_controller: RTL and testbench
===================================

# piece_controller

Active-tetromino controller driving the playfield board module. It owns the falling piece: type, rotation, origin, gravity, input handling, lock and spawn. Each cycle it presents the piece's packed cell coordinates and the five move candidates to the board, consumes `can_move` and `BOARD_BUSY`, and pulses `get_new_block` to lock the piece in place.

## Interface
- `GRAVITY_FRAMES`, default 48: frame ticks per automatic drop; legal range 1..63.
- `SPAWN_X`, default 3: origin x of a new piece. Spawn origin y is fixed at 0.
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk_rising_edge`  in  1  one-cycle pulse per 60 Hz frame.
- `start`  in  1  starts the game from IDLE.
- `key_left`, `key_right`, `key_down`, `key_rot_l`, `key_rot_r`  in  1 each  level key inputs.
- `can_move`  in  5  legality bits from the board: [4] left, [3] right, [2] rotate right, [1] rotate left, [0] down.
- `BOARD_BUSY`  in  1  board is clearing or dropping rows.
- `x_block`, `y_block`  out  20 each  current cells. Cell k sits at bits [19-5k:15-5k].
- `save_xblock`, `save_yblock`  out  20 each  cells presented on the previous cycle (erase set).
- `x_move_left`, `y_move_left`, `x_move_right`, `y_move_right`, `x_move_down`, `y_move_down`, `x_rotate_left`, `y_rotate_left`, `x_rotate_right`, `y_rotate_right`  out  20 each  candidate cells.
- `get_new_block`  out  1  one-cycle lock pulse.
- `block`  out  block_color  colour of the piece. Piece index p maps to block_color value p+1; EMPTY is 0.
- `x_coord`, `y_coord`  out  5 each  piece origin (top-left of the 4x4 box).
- `game_over`  out  1  sticky until reset.

## Operation
- **Piece encoding**
  - Piece index 0..6 = I, O, T, S, Z, J, L. Rotation is 0..3.
  - Cell = origin + (dx,dy) from an SRS 4x4 offset ROM. Arithmetic is 5-bit modular, so negative results wrap to 31.. and the board rejects them as out of bounds.
  - Rotation 0 offsets: I (0,1)(1,1)(2,1)(3,1); O (1,0)(2,0)(1,1)(2,1); T (1,0)(0,1)(1,1)(2,1).
  - T rotation 1: (1,0)(1,1)(2,1)(1,2).
- **Candidates**
  - Left/right: origin x ∓ 1.
  - Down: origin y + 1.
  - Rotate right/left: rotation ± 1 mod 4, with no wall kicks.
  - All candidates are combinational from the registered piece state.
- **Save path**
  - `save_*` is a register loaded from `x_block`/`y_block` every cycle.
  - Exception: in SPAWN, `save_*` equals the new spawn cells on that same cycle.
- **Random piece source**
  - 7-bit Fibonacci LFSR, taps x^7+x^6+1: shift left, new LSB = b6^b5. Reset seed is 7'h5A.
  - Piece index = lfsr[2:0], with 7 mapped to 0. The LFSR advances once per SPAWN, after sampling.
- **States**
  - IDLE: `block`=EMPTY, all coordinates 0. `start` → SPAWN.
  - SPAWN: load piece, rotation 0, origin (`SPAWN_X`,0); clear the gravity counter and drop_pending → SETTLE.
  - SETTLE: one cycle so the board reflects the new cells → ACTIVE.
  - ACTIVE: acts only on a cycle with `frame_clk_rising_edge`. It takes at most one action per tick, in this priority:
    1. rot_r rising edge
    2. rot_l rising edge
    3. left rising edge
    4. right rising edge
    5. down, when `key_down` is high or drop_pending is set.
  - Key rising edges are taken relative to the key values sampled at the previous frame tick.
  - If the action's `can_move` bit is 1: commit the new state → SETTLE.
  - If a down action is blocked → LOCK.
  - Any other blocked action is consumed; stay in ACTIVE.
  - A down action (committed or blocked) clears drop_pending and the gravity counter.
  - LOCK: `get_new_block`=1 for one cycle, with `x_block`==`save_xblock` and `y_block`==`save_yblock`. If any cell has y==0 → GAME_OVER; else → WAIT_BUSY.
  - WAIT_BUSY: ignore the first cycle. Then stay while `BOARD_BUSY`=1; → SPAWN on the first cycle with `BOARD_BUSY`=0.
  - GAME_OVER: hold the last piece's outputs (so the board rewrites the same colour), `game_over`=1, ignore `start`. Exit only via `Reset`.
- **Gravity**
  - 6-bit counter, incremented on frame ticks while in ACTIVE or SETTLE.
  - On reaching `GRAVITY_FRAMES`: set drop_pending and clear the counter. A pending drop persists until a down action executes.

## Timing
- **Reset values:** state IDLE; all coordinate outputs 0; `block`=EMPTY; `get_new_block`=0; `game_over`=0; LFSR 7'h5A; counter 0.
- **Move latency:** a committed move appears on `x_block` one cycle after the tick; `save_*` holds the old cells that cycle and matches the new cells one cycle later.
- **`can_move` sampling:** read only in ACTIVE, on a tick cycle, never in SETTLE.
- **Lock to spawn:** minimum latency is LOCK → WAIT_BUSY (2 cycles when not busy) → SPAWN. The new cells appear 3 cycles after the `get_new_block` pulse.
- **Ticks outside ACTIVE:** a frame tick during SETTLE, LOCK, WAIT_BUSY or SPAWN produces no action. It still counts for gravity if in SETTLE.
- **Reset mid-operation:** all outputs return to reset values asynchronously; no partial `get_new_block`.

## Test plan
- **Spawn:** Reset, `start` → first piece T, `block`=3, `x_block`={4,3,4,5}, `y_block`={0,1,1,1}; the second piece after a lock is J, `block`=6.
- **Left move:** `key_left` rises, tick, `can_move`[4]=1 → next cycle `x_block`={3,2,3,4}, `save_xblock`={4,3,4,5}; one cycle later `save_xblock`={3,2,3,4}. A held key causes no second move.
- **Gravity:** `GRAVITY_FRAMES`=2, no keys, `can_move`=5'b11111 → `y_block` goes +1 after every second tick. A `key_rot_r` edge on the due tick → rotation to {4,4,5,4}/{0,1,1,2}, and the drop executes on the next tick.
- **Blocked rotate:** `key_rot_r` edge with `can_move`[2]=0 → outputs unchanged, stays in ACTIVE.
- **Lock and busy:** down tick with `can_move`[0]=0 at origin y=10 → one-cycle `get_new_block` with x==save. Hold `BOARD_BUSY` high for 10 cycles → no spawn; spawn on the first cycle it is low.
- **Game over:** lock with a cell at y=0 → `game_over`=1 after the pulse; outputs frozen; `start` ignored. Then `Reset` → IDLE values.

Source files
------------

// File: rtl/piece_controller.sv
// Falling-tetromino controller: owns piece type, rotation, origin and gravity,
// presents current/erase/candidate cells to the board and pulses a lock request.
module piece_controller #(
    parameter int GRAVITY_FRAMES = 48,
    parameter int SPAWN_X        = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk_rising_edge,
    input  logic        start,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_down,
    input  logic        key_rot_l,
    input  logic        key_rot_r,
    input  logic [4:0]  can_move,
    input  logic        BOARD_BUSY,
    output logic [19:0] x_block,
    output logic [19:0] y_block,
    output logic [19:0] save_xblock,
    output logic [19:0] save_yblock,
    output logic [19:0] x_move_left,
    output logic [19:0] y_move_left,
    output logic [19:0] x_move_right,
    output logic [19:0] y_move_right,
    output logic [19:0] x_move_down,
    output logic [19:0] y_move_down,
    output logic [19:0] x_rotate_left,
    output logic [19:0] y_rotate_left,
    output logic [19:0] x_rotate_right,
    output logic [19:0] y_rotate_right,
    output logic        get_new_block,
    output logic [2:0]  block,
    output logic [4:0]  x_coord,
    output logic [4:0]  y_coord,
    output logic        game_over
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SPAWN     = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] ACTIVE    = 3'd3;
    localparam logic [2:0] LOCK      = 3'd4;
    localparam logic [2:0] WAIT_BUSY = 3'd5;
    localparam logic [2:0] GAME_OVER = 3'd6;

    // One nibble {dx,dy} per cell, cell 0 in the top nibble.
    function automatic logic [15:0] shape_rom(input logic [2:0] piece, input logic [1:0] rot);
        case ({piece, rot})
            5'b000_00: return 16'h159D;  5'b000_01: return 16'h89AB;
            5'b000_10: return 16'h26AE;  5'b000_11: return 16'h4567;
            5'b001_00, 5'b001_01, 5'b001_10, 5'b001_11: return 16'h4859;
            5'b010_00: return 16'h4159;  5'b010_01: return 16'h4596;
            5'b010_10: return 16'h1596;  5'b010_11: return 16'h4156;
            5'b011_00: return 16'h4815;  5'b011_01: return 16'h459A;
            5'b011_10: return 16'h5926;  5'b011_11: return 16'h0156;
            5'b100_00: return 16'h0459;  5'b100_01: return 16'h8596;
            5'b100_10: return 16'h156A;  5'b100_11: return 16'h4152;
            5'b101_00: return 16'h0159;  5'b101_01: return 16'h4856;
            5'b101_10: return 16'h159A;  5'b101_11: return 16'h4526;
            5'b110_00: return 16'h8159;  5'b110_01: return 16'h456A;
            5'b110_10: return 16'h1592;  5'b110_11: return 16'h0456;
            default:   return 16'h0000;
        endcase
    endfunction

    // Returns {x cells, y cells}; 5-bit wraparound is left for the board to reject.
    function automatic logic [39:0] place(input logic [15:0] off, input logic [4:0] ox,
                                          input logic [4:0] oy);
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[39-5*k -: 5] = ox + {3'b000, off[15-4*k -: 2]};
            r[19-5*k -: 5] = oy + {3'b000, off[13-4*k -: 2]};
        end
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  piece_q, piece_d;
    logic [1:0]  rot_q, rot_d;
    logic [4:0]  ox_q, ox_d, oy_q, oy_d;
    logic [5:0]  grav_q, grav_d;
    logic        pending_q, pending_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [3:0]  keys_prev_q, keys_prev_d;
    logic [19:0] save_x_q, save_x_d, save_y_q, save_y_d;
    logic        wait_first_q, wait_first_d;

    logic [2:0]  spawn_piece, cur_piece;
    logic [1:0]  cur_rot;
    logic [4:0]  cur_ox, cur_oy;
    logic        showing, grav_due;
    logic [39:0] cur_cells, left_cells, right_cells, down_cells, rl_cells, rr_cells;
    logic [3:0]  keys_now, edges, cell_top;

    assign spawn_piece = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    // During SPAWN the new piece is shown before it is registered.
    assign cur_piece   = (state_q == SPAWN) ? spawn_piece : piece_q;
    assign cur_rot     = (state_q == SPAWN) ? 2'd0 : rot_q;
    assign cur_ox      = (state_q == SPAWN) ? 5'(SPAWN_X) : ox_q;
    assign cur_oy      = (state_q == SPAWN) ? 5'd0 : oy_q;
    assign showing     = (state_q != IDLE);

    assign cur_cells   = place(shape_rom(cur_piece, cur_rot), cur_ox, cur_oy);
    assign left_cells  = place(shape_rom(cur_piece, cur_rot), cur_ox - 5'd1, cur_oy);
    assign right_cells = place(shape_rom(cur_piece, cur_rot), cur_ox + 5'd1, cur_oy);
    assign down_cells  = place(shape_rom(cur_piece, cur_rot), cur_ox, cur_oy + 5'd1);
    assign rl_cells    = place(shape_rom(cur_piece, cur_rot - 2'd1), cur_ox, cur_oy);
    assign rr_cells    = place(shape_rom(cur_piece, cur_rot + 2'd1), cur_ox, cur_oy);

    assign x_block        = showing ? cur_cells[39:20]   : '0;
    assign y_block        = showing ? cur_cells[19:0]    : '0;
    assign x_move_left    = showing ? left_cells[39:20]  : '0;
    assign y_move_left    = showing ? left_cells[19:0]   : '0;
    assign x_move_right   = showing ? right_cells[39:20] : '0;
    assign y_move_right   = showing ? right_cells[19:0]  : '0;
    assign x_move_down    = showing ? down_cells[39:20]  : '0;
    assign y_move_down    = showing ? down_cells[19:0]   : '0;
    assign x_rotate_left  = showing ? rl_cells[39:20]    : '0;
    assign y_rotate_left  = showing ? rl_cells[19:0]     : '0;
    assign x_rotate_right = showing ? rr_cells[39:20]    : '0;
    assign y_rotate_right = showing ? rr_cells[19:0]     : '0;
    assign save_xblock    = (state_q == SPAWN) ? x_block : save_x_q;
    assign save_yblock    = (state_q == SPAWN) ? y_block : save_y_q;
    assign block          = showing ? cur_piece + 3'd1 : 3'd0;
    assign x_coord        = showing ? cur_ox : 5'd0;
    assign y_coord        = showing ? cur_oy : 5'd0;
    assign get_new_block  = (state_q == LOCK);
    assign game_over      = (state_q == GAME_OVER);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_top
            assign cell_top[gi] = (y_block[19-5*gi -: 5] == 5'd0);
        end
    endgenerate

    assign keys_now = {key_rot_r, key_rot_l, key_left, key_right};
    assign edges    = keys_now & ~keys_prev_q;
    assign grav_due = ({1'b0, grav_q} + 7'd1) == 7'(GRAVITY_FRAMES);

    always_comb begin
        state_d      = state_q;
        piece_d      = piece_q;
        rot_d        = rot_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        grav_d       = grav_q;
        pending_d    = pending_q;
        lfsr_d       = lfsr_q;
        wait_first_d = wait_first_q;
        save_x_d     = x_block;
        save_y_d     = y_block;
        keys_prev_d  = frame_clk_rising_edge ? keys_now : keys_prev_q;

        if (frame_clk_rising_edge && (state_q == ACTIVE || state_q == SETTLE)) begin
            if (grav_due) begin
                pending_d = 1'b1;
                grav_d    = '0;
            end else begin
                grav_d = grav_q + 6'd1;
            end
        end

        case (state_q)
            IDLE: if (start) state_d = SPAWN;
            SPAWN: begin
                piece_d   = spawn_piece;
                rot_d     = 2'd0;
                ox_d      = 5'(SPAWN_X);
                oy_d      = 5'd0;
                grav_d    = '0;
                pending_d = 1'b0;
                lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                state_d   = SETTLE;
            end
            SETTLE: state_d = ACTIVE;
            ACTIVE: if (frame_clk_rising_edge) begin
                if (edges[3]) begin
                    if (can_move[2]) begin rot_d = rot_q + 2'd1; state_d = SETTLE; end
                end else if (edges[2]) begin
                    if (can_move[1]) begin rot_d = rot_q - 2'd1; state_d = SETTLE; end
                end else if (edges[1]) begin
                    if (can_move[4]) begin ox_d = ox_q - 5'd1; state_d = SETTLE; end
                end else if (edges[0]) begin
                    if (can_move[3]) begin ox_d = ox_q + 5'd1; state_d = SETTLE; end
                end else if (key_down || pending_q || grav_due) begin
                    pending_d = 1'b0;
                    grav_d    = '0;
                    if (can_move[0]) begin
                        oy_d    = oy_q + 5'd1;
                        state_d = SETTLE;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                wait_first_d = 1'b1;
                state_d      = (|cell_top) ? GAME_OVER : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wait_first_q) wait_first_d = 1'b0;
                else if (!BOARD_BUSY) state_d = SPAWN;
            end
            GAME_OVER: state_d = GAME_OVER;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            piece_q      <= '0;
            rot_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            grav_q       <= '0;
            pending_q    <= 1'b0;
            lfsr_q       <= 7'h5A;
            keys_prev_q  <= '0;
            save_x_q     <= '0;
            save_y_q     <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            piece_q      <= piece_d;
            rot_q        <= rot_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            grav_q       <= grav_d;
            pending_q    <= pending_d;
            lfsr_q       <= lfsr_d;
            keys_prev_q  <= keys_prev_d;
            save_x_q     <= save_x_d;
            save_y_q     <= save_y_d;
            wait_first_q <= wait_first_d;
        end
    end
endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, moves, gravity, blocked rotate,
// lock with busy board, lock-to-spawn latency, game over and async reset.
module tb_piece_controller;
    logic        Clk = 1'b0;
    logic        Reset, tick, start;
    logic        kl, kr, kd, krl, krr, busy;
    logic [4:0]  can_move;
    logic [19:0] x_block, y_block, save_xblock, save_yblock;
    logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right;
    logic [19:0] x_move_down, y_move_down, x_rotate_left, y_rotate_left;
    logic [19:0] x_rotate_right, y_rotate_right;
    logic        get_new_block, game_over;
    logic [2:0]  block;
    logic [4:0]  x_coord, y_coord;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    piece_controller #(.GRAVITY_FRAMES(2), .SPAWN_X(3)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(tick), .start(start),
        .key_left(kl), .key_right(kr), .key_down(kd), .key_rot_l(krl), .key_rot_r(krr),
        .can_move(can_move), .BOARD_BUSY(busy),
        .x_block(x_block), .y_block(y_block), .save_xblock(save_xblock), .save_yblock(save_yblock),
        .x_move_left(x_move_left), .y_move_left(y_move_left),
        .x_move_right(x_move_right), .y_move_right(y_move_right),
        .x_move_down(x_move_down), .y_move_down(y_move_down),
        .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
        .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
        .get_new_block(get_new_block), .block(block),
        .x_coord(x_coord), .y_coord(y_coord), .game_over(game_over)
    );

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] p4(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [4:0] d);
        return {a, b, c, d};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; tick = 0; start = 0; kl = 0; kr = 0; kd = 0; krl = 0; krr = 0;
        busy = 0; can_move = 5'b11111;
        #12;
        check("rst_block", {17'd0, block}, 20'd0);
        check("rst_xblock", x_block, 20'd0);
        check("rst_yblock", y_block, 20'd0);
        check("rst_gnb", {19'd0, get_new_block}, 20'd0);
        check("rst_gameover", {19'd0, game_over}, 20'd0);
        check("rst_xcoord", {15'd0, x_coord}, 20'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // First spawn: LFSR 0x5A gives T at origin (3,0)
        start = 1;
        cyc(1);
        start = 0;
        check("spawn_block", {17'd0, block}, 20'd3);
        check("spawn_x", x_block, p4(4, 3, 4, 5));
        check("spawn_y", y_block, p4(0, 1, 1, 1));
        check("spawn_save_x", save_xblock, p4(4, 3, 4, 5));
        cyc(2);
        check("cand_left_x", x_move_left, p4(3, 2, 3, 4));
        check("cand_right_x", x_move_right, p4(5, 4, 5, 6));
        check("cand_down_y", y_move_down, p4(1, 2, 2, 2));
        check("cand_rr_x", x_rotate_right, p4(4, 4, 5, 4));
        check("cand_rr_y", y_rotate_right, p4(0, 1, 1, 2));
        check("cand_rl_x", x_rotate_left, p4(4, 3, 4, 4));
        check("cand_rl_y", y_rotate_left, p4(0, 1, 1, 2));

        // Left move, then held key (gravity due on this second tick)
        kl = 1; tick = 1;
        cyc(1);
        tick = 0;
        check("left_x", x_block, p4(3, 2, 3, 4));
        check("left_save_old", save_xblock, p4(4, 3, 4, 5));
        cyc(1);
        check("left_save_new", save_xblock, p4(3, 2, 3, 4));
        tick = 1;
        cyc(1);
        tick = 0;
        check("held_left_x", x_block, p4(3, 2, 3, 4));
        check("grav_drop1_y", y_block, p4(1, 2, 2, 2));
        cyc(1);

        // Gravity every second tick
        tick = 1; cyc(1); tick = 0;
        check("grav_nodrop", {15'd0, y_coord}, 20'd1);
        cyc(1);
        tick = 1; cyc(1); tick = 0;
        check("grav_drop2", {15'd0, y_coord}, 20'd2);
        cyc(1);
        tick = 1; cyc(1); tick = 0;
        cyc(1);
        // Rotate wins on the due tick; drop follows on the next tick
        krr = 1; tick = 1;
        cyc(1);
        tick = 0;
        check("rot_due_x", x_block, p4(3, 3, 4, 3));
        check("rot_due_y", y_block, p4(2, 3, 3, 4));
        cyc(1);
        tick = 1; cyc(1); tick = 0;
        check("pending_drop_y", y_block, p4(3, 4, 4, 5));
        cyc(1);

        // Blocked rotate: consumed, stays ACTIVE (pending drop acts on the very next tick)
        krr = 0; tick = 1; cyc(1); tick = 0;
        cyc(1);
        krr = 1; can_move = 5'b11011; tick = 1;
        cyc(1);
        check("blk_rot_x", x_block, p4(3, 3, 4, 3));
        check("blk_rot_ycoord", {15'd0, y_coord}, 20'd3);
        can_move = 5'b11111;
        cyc(1);
        tick = 0;
        check("blk_rot_active", {15'd0, y_coord}, 20'd4);
        cyc(1);

        // Soft drop to y=10, then blocked down locks
        kd = 1;
        for (int i = 0; i < 6; i++) begin
            tick = 1; cyc(1); tick = 0; cyc(1);
        end
        check("soft_drop_y", {15'd0, y_coord}, 20'd10);
        can_move = 5'b11110; tick = 1;
        cyc(1);
        tick = 0; kd = 0;
        check("lock_gnb", {19'd0, get_new_block}, 20'd1);
        check("lock_x", x_block, p4(3, 3, 4, 3));
        check("lock_save_x", save_xblock, p4(3, 3, 4, 3));
        check("lock_save_y", save_yblock, p4(10, 11, 11, 12));
        busy = 1;
        cyc(1);
        check("lock_pulse_end", {19'd0, get_new_block}, 20'd0);
        cyc(9);
        check("busy_no_spawn", {17'd0, block}, 20'd3);
        busy = 0;
        cyc(1);
        check("spawn2_block", {17'd0, block}, 20'd6);
        check("spawn2_x", x_block, p4(3, 3, 4, 5));
        check("spawn2_save_x", save_xblock, p4(3, 3, 4, 5));

        // Minimum lock-to-spawn latency with idle board
        cyc(2);
        can_move = 5'b11111; kd = 1; tick = 1;
        cyc(1);
        tick = 0;
        check("j_down", {15'd0, y_coord}, 20'd1);
        cyc(1);
        can_move = 5'b11110; tick = 1;
        cyc(1);
        tick = 0; kd = 0;
        check("lock2_gnb", {19'd0, get_new_block}, 20'd1);
        cyc(1);
        check("wait1_block", {17'd0, block}, 20'd6);
        cyc(1);
        check("wait2_block", {17'd0, block}, 20'd6);
        cyc(1);
        check("spawn3_block", {17'd0, block}, 20'd4);
        check("spawn3_x", x_block, p4(4, 5, 3, 4));
        check("spawn3_y", y_block, p4(0, 0, 1, 1));

        // Lock with a cell at y=0 -> game over
        cyc(2);
        kd = 1; can_move = 5'b11110; tick = 1;
        cyc(1);
        tick = 0; kd = 0;
        check("go_lock_gnb", {19'd0, get_new_block}, 20'd1);
        check("go_not_yet", {19'd0, game_over}, 20'd0);
        cyc(1);
        check("go_flag", {19'd0, game_over}, 20'd1);
        check("go_gnb_low", {19'd0, get_new_block}, 20'd0);
        start = 1;
        cyc(3);
        start = 0;
        check("go_sticky", {19'd0, game_over}, 20'd1);
        check("go_block", {17'd0, block}, 20'd4);
        check("go_x", x_block, p4(4, 5, 3, 4));
        check("go_y", y_block, p4(0, 0, 1, 1));
        check("go_save_x", save_xblock, p4(4, 5, 3, 4));

        // Asynchronous reset mid-cycle
        #2;
        Reset = 1'b1;
        #1;
        check("areset_block", {17'd0, block}, 20'd0);
        check("areset_x", x_block, 20'd0);
        check("areset_save_x", save_xblock, 20'd0);
        check("areset_gameover", {19'd0, game_over}, 20'd0);
        check("areset_ycoord", {15'd0, y_coord}, 20'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
